game_controller: RTL and testbench

Top-level Bulls & Cows game sequencer that sits directly upstream of the display manager. It owns the game state machine, debounces the confirm button to a single-cycle tick, and captures both players' secrets. It scores each guess against the opponent's secret and keeps per-player win tallies. Its `current_state`, `bulls` and `cows` outputs drive the display stage.

---
 rtl/game_controller.sv | 174 +++++++++++++++++
 tb/tb_game_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// Bulls & Cows game sequencer: confirm edge detect, secret capture, guess scoring,
// win/guess tallies. All outputs are registered.
module game_controller #(
    parameter int WIN_MAX   = 9,
    parameter int GUESS_MAX = 99
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        confirm,
    input  logic [15:0] code,
    output logic [2:0]  current_state,
    output logic [3:0]  bulls,
    output logic [3:0]  cows,
    output logic        next_player,
    output logic        code_error,
    output logic [3:0]  wins_j1,
    output logic [3:0]  wins_j2,
    output logic [6:0]  guess_count
);

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        SECRET_J1      = 3'd1,
        SECRET_J2      = 3'd2,
        GUESS_J1       = 3'd3,
        GUESS_J2       = 3'd4,
        WIN_J1         = 3'd5,
        WIN_J2         = 3'd6,
        DISPLAY_RESULT = 3'd7
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_btn_prev, r_tick;
    logic [15:0] r_secret1, r_secret2, w_secret1_nxt, w_secret2_nxt;
    logic [3:0]  r_bulls, r_cows, w_bulls_nxt, w_cows_nxt;
    logic        r_next_player, w_next_player_nxt;
    logic        r_code_error, w_code_error_nxt;
    logic [3:0]  r_wins_j1, r_wins_j2, w_wins_j1_nxt, w_wins_j2_nxt;
    logic [6:0]  r_guess_count, w_guess_count_nxt;
    logic        w_code_ok;
    logic [15:0] w_target;
    logic [3:0]  w_score_b, w_score_c;

    function automatic logic code_valid(input logic [15:0] c);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c[4*i +: 4] > 4'd9) ok = 1'b0;
            for (int j = i + 1; j < 4; j++)
                if (c[4*i +: 4] == c[4*j +: 4]) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [7:0] score(input logic [15:0] g, input logic [15:0] s);
        logic [3:0] b, c;
        b = 4'd0;
        c = 4'd0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (g[4*i +: 4] == s[4*j +: 4]) begin
                    if (i == j) b = b + 4'd1;
                    else        c = c + 4'd1;
                end
        return {b, c};
    endfunction

    assign w_code_ok = code_valid(code);
    assign w_target  = (r_state == GUESS_J1) ? r_secret2 : r_secret1;
    assign {w_score_b, w_score_c} = score(code, w_target);

    // btn_prev follows confirm even in reset, so a held button cannot tick afterwards
    always_ff @(posedge clock) begin
        r_btn_prev <= confirm;
        if (reset) r_tick <= 1'b0;
        else       r_tick <= confirm & ~r_btn_prev;
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_secret1_nxt     = r_secret1;
        w_secret2_nxt     = r_secret2;
        w_bulls_nxt       = r_bulls;
        w_cows_nxt        = r_cows;
        w_next_player_nxt = r_next_player;
        w_code_error_nxt  = 1'b0;
        w_wins_j1_nxt     = r_wins_j1;
        w_wins_j2_nxt     = r_wins_j2;
        w_guess_count_nxt = r_guess_count;
        if (r_tick) begin
            case (r_state)
                IDLE: begin
                    w_state_nxt       = SECRET_J1;
                    w_guess_count_nxt = 7'd0;
                    w_bulls_nxt       = 4'd0;
                    w_cows_nxt        = 4'd0;
                    w_next_player_nxt = 1'b0;
                end
                SECRET_J1: begin
                    if (w_code_ok) begin
                        w_secret1_nxt = code;
                        w_state_nxt   = SECRET_J2;
                    end else w_code_error_nxt = 1'b1;
                end
                SECRET_J2: begin
                    if (w_code_ok) begin
                        w_secret2_nxt = code;
                        w_state_nxt   = GUESS_J1;
                    end else w_code_error_nxt = 1'b1;
                end
                GUESS_J1, GUESS_J2: begin
                    if (!w_code_ok) w_code_error_nxt = 1'b1;
                    else begin
                        w_bulls_nxt = w_score_b;
                        w_cows_nxt  = w_score_c;
                        if (r_guess_count != 7'(GUESS_MAX))
                            w_guess_count_nxt = r_guess_count + 7'd1;
                        if (w_score_b == 4'd4) begin
                            if (r_state == GUESS_J1) begin
                                w_state_nxt = WIN_J1;
                                if (r_wins_j1 != 4'(WIN_MAX)) w_wins_j1_nxt = r_wins_j1 + 4'd1;
                            end else begin
                                w_state_nxt = WIN_J2;
                                if (r_wins_j2 != 4'(WIN_MAX)) w_wins_j2_nxt = r_wins_j2 + 4'd1;
                            end
                        end else begin
                            w_state_nxt       = DISPLAY_RESULT;
                            w_next_player_nxt = ~r_next_player;
                        end
                    end
                end
                DISPLAY_RESULT: w_state_nxt = r_next_player ? GUESS_J2 : GUESS_J1;
                WIN_J1, WIN_J2: w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_secret1     <= 16'd0;
            r_secret2     <= 16'd0;
            r_bulls       <= 4'd0;
            r_cows        <= 4'd0;
            r_next_player <= 1'b0;
            r_code_error  <= 1'b0;
            r_wins_j1     <= 4'd0;
            r_wins_j2     <= 4'd0;
            r_guess_count <= 7'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_secret1     <= w_secret1_nxt;
            r_secret2     <= w_secret2_nxt;
            r_bulls       <= w_bulls_nxt;
            r_cows        <= w_cows_nxt;
            r_next_player <= w_next_player_nxt;
            r_code_error  <= w_code_error_nxt;
            r_wins_j1     <= w_wins_j1_nxt;
            r_wins_j2     <= w_wins_j2_nxt;
            r_guess_count <= w_guess_count_nxt;
        end
    end

    assign current_state = r_state;
    assign bulls         = r_bulls;
    assign cows          = r_cows;
    assign next_player   = r_next_player;
    assign code_error    = r_code_error;
    assign wins_j1       = r_wins_j1;
    assign wins_j2       = r_wins_j2;
    assign guess_count   = r_guess_count;

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: a rule-level game model predicts the outputs
// of every confirm press; a monitor compares them when they are due.
module tb_game_controller;

    localparam int WIN_MAX   = 9;
    localparam int GUESS_MAX = 99;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        confirm = 1'b0;
    logic [15:0] code = 16'd0;
    logic [2:0]  current_state;
    logic [3:0]  bulls, cows, wins_j1, wins_j2;
    logic        next_player, code_error;
    logic [6:0]  guess_count;

    game_controller #(.WIN_MAX(WIN_MAX), .GUESS_MAX(GUESS_MAX)) dut (
        .clock(clock), .reset(reset), .confirm(confirm), .code(code),
        .current_state(current_state), .bulls(bulls), .cows(cows),
        .next_player(next_player), .code_error(code_error),
        .wins_j1(wins_j1), .wins_j2(wins_j2), .guess_count(guess_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [2:0] st;
        logic [3:0] b, c, w1, w2;
        logic       np, err;
        logic [6:0] gc;
    } exp_t;
    exp_t q[$];

    int vectors = 0;
    int miscompares = 0;

    // Reference game: state numbers as the display sees them
    int         m_state, m_b, m_c, m_w1, m_w2, m_gc;
    bit         m_np, m_err;
    logic [15:0] m_sec1, m_sec2;

    function automatic int digit(logic [15:0] c, int i);
        return int'(c[15-4*i -: 4]);
    endfunction

    function automatic bit m_valid(logic [15:0] c);
        bit [15:0] seen;
        seen = '0;
        for (int i = 0; i < 4; i++) begin
            if (digit(c, i) > 9) return 1'b0;
            if (seen[digit(c, i)]) return 1'b0;
            seen[digit(c, i)] = 1'b1;
        end
        return 1'b1;
    endfunction

    function automatic bit [15:0] digit_set(logic [15:0] c);
        bit [15:0] s;
        s = '0;
        for (int i = 0; i < 4; i++) s[digit(c, i)] = 1'b1;
        return s;
    endfunction

    task automatic model_reset();
        m_state = 0; m_b = 0; m_c = 0; m_w1 = 0; m_w2 = 0; m_gc = 0;
        m_np = 0; m_err = 0; m_sec1 = 0; m_sec2 = 0;
    endtask

    task automatic model_press(logic [15:0] c);
        int common;
        logic [15:0] sec;
        m_err = 0;
        case (m_state)
            0: begin m_state = 1; m_gc = 0; m_b = 0; m_c = 0; m_np = 0; end
            1: if (m_valid(c)) begin m_sec1 = c; m_state = 2; end else m_err = 1;
            2: if (m_valid(c)) begin m_sec2 = c; m_state = 3; end else m_err = 1;
            3, 4: begin
                if (!m_valid(c)) m_err = 1;
                else begin
                    sec = (m_state == 3) ? m_sec2 : m_sec1;
                    m_b = 0;
                    for (int i = 0; i < 4; i++) if (digit(c, i) == digit(sec, i)) m_b++;
                    common = $countones(digit_set(c) & digit_set(sec));
                    m_c = common - m_b;
                    if (m_gc < GUESS_MAX) m_gc++;
                    if (m_b == 4) begin
                        if (m_state == 3) begin m_state = 5; if (m_w1 < WIN_MAX) m_w1++; end
                        else              begin m_state = 6; if (m_w2 < WIN_MAX) m_w2++; end
                    end else begin
                        m_state = 7;
                        m_np = !m_np;
                    end
                end
            end
            7: m_state = m_np ? 4 : 3;
            default: m_state = 0;
        endcase
    endtask

    task automatic push_exp(int due, bit err);
        exp_t e;
        e.due = due; e.st = 3'(m_state); e.b = 4'(m_b); e.c = 4'(m_c);
        e.w1 = 4'(m_w1); e.w2 = 4'(m_w2); e.np = m_np; e.err = err; e.gc = 7'(m_gc);
        q.push_back(e);
    endtask

    always @(negedge clock) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            if (e.due != cyc ||
                {current_state, bulls, cows, next_player, code_error, wins_j1, wins_j2, guess_count} !==
                {e.st, e.b, e.c, e.np, e.err, e.w1, e.w2, e.gc}) begin
                miscompares++;
                $display("FAIL outputs@cyc%0d (due %0d): got st=%0d b=%0d c=%0d np=%0d err=%0d w1=%0d w2=%0d gc=%0d, want st=%0d b=%0d c=%0d np=%0d err=%0d w1=%0d w2=%0d gc=%0d",
                         cyc, e.due, current_state, bulls, cows, next_player, code_error, wins_j1, wins_j2, guess_count,
                         e.st, e.b, e.c, e.np, e.err, e.w1, e.w2, e.gc);
            end
        end
    end

    task automatic press(logic [15:0] c, bit rst_at_tick = 1'b0);
        int n;
        @(negedge clock);
        confirm = 1'b1;
        code = c;
        n = cyc;
        if (rst_at_tick) model_reset(); else model_press(c);
        push_exp(n + 2, m_err);
        push_exp(n + 3, 1'b0);
        @(negedge clock);
        if (rst_at_tick) reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        confirm = 1'b0;
        code = 16'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clock);
    endtask

    function automatic logic [15:0] rand_valid();
        bit [9:0] used;
        int d;
        logic [15:0] r;
        used = '0;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            do d = $urandom_range(0, 9); while (used[d]);
            used[d] = 1'b1;
            r = {r[11:0], 4'(d)};
        end
        return r;
    endfunction

    function automatic logic [15:0] rand_miss(logic [15:0] sec);
        logic [15:0] r;
        do r = rand_valid(); while (r == sec);
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cyc %0d, %0d expectations pending", cyc, q.size());
        $fatal(1);
    end

    initial begin
        int n;
        int r;
        logic [15:0] c;
        model_reset();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        push_exp(cyc + 1, 1'b0);

        // Hold confirm: one transition only
        @(negedge clock);
        confirm = 1'b1;
        n = cyc;
        model_press(16'h0000);
        push_exp(n + 2, 1'b0);
        push_exp(n + 3, 1'b0);
        push_exp(n + 10, 1'b0);
        push_exp(n + 20, 1'b0);
        repeat (20) @(negedge clock);
        confirm = 1'b0;

        press(16'h1123);
        press(16'h1A23);
        press(16'h1234);
        press(16'h5678);
        press(16'h5687);
        press(16'h0000);
        press(16'h4321);
        press(16'h0000);
        press(16'h5678);
        press(16'h0000);

        repeat (150) begin
            r = $urandom_range(0, 7);
            if (r == 0) c = 16'($urandom);
            else if (r <= 2 && m_state == 3) c = m_sec2;
            else if (r <= 2 && m_state == 4) c = m_sec1;
            else c = rand_valid();
            press(c);
        end

        // Reset colliding with a valid J2 guess tick
        press(16'h0000, 1'b1);
        press(16'h0000);
        press(16'h1234);
        press(16'h5678);
        press(16'h9012);
        press(16'h0000);
        press(16'h1234, 1'b1);

        repeat (11) begin
            press(16'h0000);
            c = rand_valid();
            press(c);
            press(rand_miss(c));
            press(m_sec2);
            press(16'($urandom));
        end

        press(16'h0000);
        press(16'h1234);
        press(16'h5678);
        repeat (105) begin
            press(rand_miss(m_state == 3 ? m_sec2 : m_sec1));
            press(16'($urandom));
        end

        repeat (6) @(negedge clock);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL pending: %0d expectations never checked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
